// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: phase strobes, bitwise DAC switching and a one-deep
// result holding register with overrun detection.
module sar_sequencer #(
   parameter int NBITS       = 16,
   parameter int INIT_CYCLES = 1,
   parameter int SAMP_CYCLES = 2,
   parameter int COMP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             cont,
   input  logic             abort,
   input  logic             en_samp_p,
   input  logic             en_samp_n,
   input  logic             en_comp,
   input  logic [NBITS-1:0] dac_astate_p,
   input  logic [NBITS-1:0] dac_astate_n,
   input  logic [NBITS-1:0] dac_bstate_p,
   input  logic [NBITS-1:0] dac_bstate_n,
   input  logic             comp_out_p,
   output logic             seq_init,
   output logic             seq_samp_p,
   output logic             seq_samp_n,
   output logic             seq_comp,
   output logic             seq_update,
   output logic [NBITS-1:0] dac_state_p,
   output logic [NBITS-1:0] dac_state_n,
   output logic             busy,
   output logic [NBITS-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             overrun,
   input  logic             overrun_clr
);
   localparam int KW = $clog2(NBITS);
   localparam int CW = 16;
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0] SAMP_LAST = CW'(SAMP_CYCLES - 1);
   localparam logic [CW-1:0] COMP_LAST = CW'(COMP_CYCLES - 1);
   localparam logic [KW-1:0] K_MSB     = KW'(NBITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_SAMP   = 3'd2;
   localparam logic [2:0] S_COMP   = 3'd3;
   localparam logic [2:0] S_UPDATE = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]       state, nstate;
   logic [CW-1:0]    cnt, ncnt;
   logic [KW-1:0]    k;
   logic             d;
   logic [NBITS-1:0] code;
   logic             enter_init, last_comp, upd, done_wr;

   always_comb begin
      nstate = state;
      ncnt   = cnt;
      case (state)
         S_IDLE: if (start) begin
            nstate = S_INIT;
            ncnt   = '0;
         end
         S_INIT: if (cnt == INIT_LAST) begin
            nstate = S_SAMP;
            ncnt   = '0;
         end else ncnt = cnt + CW'(1);
         S_SAMP: if (cnt == SAMP_LAST) begin
            nstate = S_COMP;
            ncnt   = '0;
         end else ncnt = cnt + CW'(1);
         S_COMP: if (cnt == COMP_LAST) begin
            nstate = S_UPDATE;
            ncnt   = '0;
         end else ncnt = cnt + CW'(1);
         S_UPDATE: begin
            nstate = (k == '0) ? S_DONE : S_COMP;
            ncnt   = '0;
         end
         S_DONE: begin
            nstate = cont ? S_INIT : S_IDLE;
            ncnt   = '0;
         end
         default: begin
            nstate = S_IDLE;
            ncnt   = '0;
         end
      endcase
      if (abort) begin
         nstate = S_IDLE;
         ncnt   = '0;
      end
   end

   assign enter_init = (nstate == S_INIT) && (state != S_INIT);
   assign last_comp  = (state == S_COMP) && (cnt == COMP_LAST);
   assign upd        = (state == S_UPDATE) && !abort;
   assign done_wr    = (state == S_DONE) && !abort;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
      end
   end

   // Strobes are registered from the next state so they align exactly with the phase.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         seq_init   <= 1'b0;
         seq_samp_p <= 1'b0;
         seq_samp_n <= 1'b0;
         seq_comp   <= 1'b0;
         seq_update <= 1'b0;
         busy       <= 1'b0;
      end else begin
         seq_init   <= (nstate == S_INIT);
         seq_samp_p <= (nstate == S_SAMP) && en_samp_p;
         seq_samp_n <= (nstate == S_SAMP) && en_samp_n;
         seq_comp   <= (nstate == S_COMP) && en_comp;
         seq_update <= (nstate == S_UPDATE);
         busy       <= (nstate != S_IDLE);
      end
   end

   // The n-side switches on the complement of the same p-side decision.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         k           <= K_MSB;
         d           <= 1'b0;
         code        <= '0;
         dac_state_p <= '0;
         dac_state_n <= '0;
      end else begin
         if (last_comp) d <= comp_out_p;
         if (enter_init) begin
            k           <= K_MSB;
            code        <= '0;
            dac_state_p <= dac_astate_p;
            dac_state_n <= dac_astate_n;
         end else if (upd) begin
            code[k] <= d;
            if (d) dac_state_p[k] <= dac_bstate_p[k];
            else   dac_state_n[k] <= dac_bstate_n[k];
            if (k != '0) k <= k - KW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         result       <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (done_wr) begin
         result       <= code;
         result_valid <= 1'b1;
         if (result_valid && !result_ready) overrun <= 1'b1;
         else if (overrun_clr)              overrun <= 1'b0;
      end else begin
         if (result_valid && result_ready) result_valid <= 1'b0;
         if (overrun_clr)                  overrun      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: schedule/handshake reference model, randomized decisions.
module tb_sar_sequencer;
   logic clk = 1'b0;
   logic rst_b, start, cont, abort, en_samp_p, en_samp_n, en_comp, comp_out_p;
   logic result_ready, overrun_clr, start_s, comp_s;
   logic [15:0] ap, an, bp, bn;
   logic seq_init, seq_samp_p, seq_samp_n, seq_comp, seq_update, busy, result_valid, overrun;
   logic [15:0] dac_state_p, dac_state_n, result;
   logic seq_init_s, seq_samp_p_s, seq_samp_n_s, seq_comp_s, seq_update_s, busy_s, rv_s, ovr_s;
   logic [3:0] dac_p_s, dac_n_s, result_s;

   int n_vec = 0, n_err = 0;
   logic m_rv = 1'b0, m_ovr = 1'b0;
   logic [15:0] m_res = '0;

   always #5 clk = ~clk;

   sar_sequencer u_dut (
      .clk(clk), .rst_b(rst_b), .start(start), .cont(cont), .abort(abort),
      .en_samp_p(en_samp_p), .en_samp_n(en_samp_n), .en_comp(en_comp),
      .dac_astate_p(ap), .dac_astate_n(an), .dac_bstate_p(bp), .dac_bstate_n(bn),
      .comp_out_p(comp_out_p), .seq_init(seq_init), .seq_samp_p(seq_samp_p),
      .seq_samp_n(seq_samp_n), .seq_comp(seq_comp), .seq_update(seq_update),
      .dac_state_p(dac_state_p), .dac_state_n(dac_state_n), .busy(busy),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .overrun(overrun), .overrun_clr(overrun_clr));

   sar_sequencer #(.NBITS(4), .INIT_CYCLES(1), .SAMP_CYCLES(2), .COMP_CYCLES(2)) u_small (
      .clk(clk), .rst_b(rst_b), .start(start_s), .cont(1'b0), .abort(1'b0),
      .en_samp_p(1'b1), .en_samp_n(1'b0), .en_comp(1'b1),
      .dac_astate_p(ap[3:0]), .dac_astate_n(an[3:0]), .dac_bstate_p(bp[3:0]), .dac_bstate_n(bn[3:0]),
      .comp_out_p(comp_s), .seq_init(seq_init_s), .seq_samp_p(seq_samp_p_s),
      .seq_samp_n(seq_samp_n_s), .seq_comp(seq_comp_s), .seq_update(seq_update_s),
      .dac_state_p(dac_p_s), .dac_state_n(dac_n_s), .busy(busy_s),
      .result(result_s), .result_valid(rv_s), .result_ready(1'b1),
      .overrun(ovr_s), .overrun_clr(1'b0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lat(int nb, int ic, int sc, int cc);
      return ic + sc + nb * (cc + 1) + 1;
   endfunction

   // Phase after edge t of a conversion: 0 idle,1 init,2 samp,3 comp,4 update,5 done
   function automatic int phase(int t, int nb, int ic, int sc, int cc, bit cm);
      int u = t - ic - sc;
      if (t < ic) return 1;
      if (u < 0) return 2;
      if (u < nb * (cc + 1)) return (u % (cc + 1) < cc) ? 3 : 4;
      if (u == nb * (cc + 1)) return 5;
      return cm ? 1 : 0;
   endfunction

   // Decision bit only in the last comparator cycle; noise everywhere else.
   function automatic logic comp_val(int t, logic [15:0] dec, int nb, int ic, int sc, int cc);
      int u = t - ic - sc;
      int j;
      if (u < 0) return 1'($urandom);
      j = u / (cc + 1);
      if (j < nb && (u % (cc + 1)) == cc - 1) return dec[nb - 1 - j];
      return 1'($urandom);
   endfunction

   task automatic tick(input bit done_edge, input logic [15:0] nres);
      logic rdy, clr;
      rdy = result_ready;
      clr = overrun_clr;
      @(posedge clk);
      if (done_edge) begin
         if (m_rv && !rdy) m_ovr = 1'b1;
         else if (clr)     m_ovr = 1'b0;
         m_rv  = 1'b1;
         m_res = nres;
      end else begin
         if (m_rv && rdy) m_rv = 1'b0;
         if (clr) m_ovr = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic chk_phase(input int ph);
      chk("seq_init",   32'(seq_init),   32'(ph == 1));
      chk("seq_samp_p", 32'(seq_samp_p), 32'(ph == 2 && en_samp_p));
      chk("seq_samp_n", 32'(seq_samp_n), 32'(ph == 2 && en_samp_n));
      chk("seq_comp",   32'(seq_comp),   32'(ph == 3 && en_comp));
      chk("seq_update", 32'(seq_update), 32'(ph == 4));
      chk("busy",       32'(busy),       32'(ph != 0));
      chk("result_valid", 32'(result_valid), 32'(m_rv));
      chk("result",     32'(result),     32'(m_res));
      chk("overrun",    32'(overrun),    32'(m_ovr));
   endtask

   task automatic chk_zero();
      chk_phase(0);
      chk("rst_dac_p", 32'(dac_state_p), 32'h0);
      chk("rst_dac_n", 32'(dac_state_n), 32'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick(1'b0, 16'h0);
         chk_phase(0);
      end
   endtask

   task automatic conv(input logic [15:0] dec, input bit chained, input bit cm, input bit rand_rdy);
      int L = lat(16, 1, 2, 1);
      cont = cm;
      if (!chained) begin
         start = 1'b1;
         tick(1'b0, 16'h0);
         start = 1'b0;
      end
      for (int t = 0; t <= L; t++) begin
         chk_phase(phase(t, 16, 1, 2, 1, cm));
         comp_out_p = comp_val(t, dec, 16, 1, 2, 1);
         if (rand_rdy) result_ready = 1'($urandom);
         if (t < L) tick(t + 1 == L, dec);
      end
      if (cm) begin
         chk("dac_p_reload", 32'(dac_state_p), 32'(ap));
         chk("dac_n_reload", 32'(dac_state_n), 32'(an));
      end else begin
         chk("dac_p", 32'(dac_state_p), 32'((ap & ~dec) | (bp & dec)));
         chk("dac_n", 32'(dac_state_n), 32'((an & dec) | (bn & ~dec)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] dec, mask;
      logic [3:0] dec_s;
      rst_b = 1'b0; start = 1'b1; cont = 1'b0; abort = 1'b0; start_s = 1'b0; comp_s = 1'b0;
      en_samp_p = 1'b1; en_samp_n = 1'b1; en_comp = 1'b1; comp_out_p = 1'b0;
      result_ready = 1'b1; overrun_clr = 1'b0;
      ap = 16'h0000; an = 16'h0000; bp = 16'hFFFF; bn = 16'hFFFF;
      #3 chk_zero();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      chk_zero();

      // First post-release edge accepts start; all-ones decisions
      conv(16'hFFFF, 1'b0, 1'b0, 1'b0);
      chk("res_ffff", 32'(result), 32'hFFFF);
      conv(16'hAAAA, 1'b0, 1'b0, 1'b0);
      chk("res_aaaa", 32'(result), 32'hAAAA);
      chk("dacn_5555", 32'(dac_state_n), 32'h5555);

      for (int i = 0; i < 5; i++) begin
         ap = 16'($urandom); an = 16'($urandom); bp = 16'($urandom); bn = 16'($urandom);
         en_samp_p = 1'($urandom); en_samp_n = 1'($urandom); en_comp = 1'($urandom);
         conv(16'($urandom), 1'b0, 1'b0, 1'b1);
      end

      // Abort in COMP at k=7: bits 15..8 already switched
      result_ready = 1'b1;
      idle(2);
      dec = 16'($urandom);
      start = 1'b1;
      tick(1'b0, 16'h0);
      start = 1'b0;
      for (int t = 0; t < 19; t++) begin
         chk_phase(phase(t, 16, 1, 2, 1, 1'b0));
         comp_out_p = comp_val(t, dec, 16, 1, 2, 1);
         tick(1'b0, 16'h0);
      end
      chk_phase(3);
      abort = 1'b1;
      tick(1'b0, 16'h0);
      abort = 1'b0;
      chk_phase(0);
      mask = 16'hFF00;
      chk("abort_dac_p", 32'(dac_state_p), 32'((ap & ~(dec & mask)) | (bp & dec & mask)));
      chk("abort_dac_n", 32'(dac_state_n), 32'((an & ~(~dec & mask)) | (bn & ~dec & mask)));
      idle(3);
      conv(16'($urandom), 1'b0, 1'b0, 1'b0);

      // Continuous mode, consumer stalled: second result overwrites and flags overrun
      result_ready = 1'b0;
      idle(1);
      conv(16'($urandom), 1'b0, 1'b1, 1'b0);
      dec = 16'($urandom);
      conv(dec, 1'b1, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 32'h1);
      chk("ovr_res", 32'(result), 32'(dec));
      overrun_clr = 1'b1;
      tick(1'b0, 16'h0);
      overrun_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'h0);
      result_ready = 1'b1;
      idle(2);

      // Reset during SAMP, start held across release
      start = 1'b1;
      tick(1'b0, 16'h0);
      tick(1'b0, 16'h0);
      chk_phase(2);
      rst_b = 1'b0;
      m_rv = 1'b0; m_ovr = 1'b0; m_res = '0;
      #1 chk_zero();
      @(posedge clk);
      #1 chk_zero();
      @(negedge clk);
      rst_b = 1'b1;
      chk_zero();
      conv(16'($urandom), 1'b0, 1'b0, 1'b0);

      // Small instance: 4 bits, 2 comparator cycles, n-side sampling disabled
      dec_s = 4'($urandom);
      start_s = 1'b1;
      tick(1'b0, 16'h0);
      start_s = 1'b0;
      for (int t = 0; t <= 16; t++) begin
         chk("s_samp_n", 32'(seq_samp_n_s), 32'h0);
         chk("s_rv", 32'(rv_s), 32'(t == 16));
         chk("s_busy", 32'(busy_s), 32'(t < 16));
         comp_s = comp_val(t, {12'h0, dec_s}, 4, 1, 2, 2);
         if (t < 16) tick(1'b0, 16'h0);
      end
      chk("s_result", 32'(result_s), 32'(dec_s));
      chk("s_dac_p", 32'(dac_p_s), 32'((ap[3:0] & ~dec_s) | (bp[3:0] & dec_s)));
      chk("s_dac_n", 32'(dac_n_s), 32'((an[3:0] & dec_s) | (bn[3:0] & ~dec_s)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sar_sequencer.md
SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 SHALL have parameter NBITS, default 16, conversion resolution and DAC state width (2..16).
REQ-002 SHALL have parameter INIT_CYCLES, default 1, INIT phase length in clocks (>=1).
REQ-003 SHALL have parameter SAMP_CYCLES, default 2, SAMP phase length in clocks (>=1).
REQ-004 SHALL have parameter COMP_CYCLES, default 1, COMP phase length per bit in clocks (>=1).
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  conversion request, sampled in IDLE only.
- cont  in  1  continuous mode: DONE goes straight to INIT.
- abort  in  1  synchronous abort, highest priority after reset.
- en_samp_p, en_samp_n  in  1 each  per-side sampling enables.
- en_comp  in  1  comparator clock enable.
- dac_astate_p, dac_astate_n  in  NBITS each  initial DAC states.
- dac_bstate_p, dac_bstate_n  in  NBITS each  switched DAC states.
- comp_out_p  in  1  comparator decision, stable during the last COMP cycle.
- seq_init, seq_samp_p, seq_samp_n, seq_comp, seq_update  out  1 each  registered phase strobes.
- dac_state_p, dac_state_n  out  NBITS each  registered DAC states.
- busy  out  1  high in every state except IDLE.
- result  out  NBITS  conversion code, MSB first.
- result_valid  out  1  result holding register full.
- result_ready  in  1  consumer accepts result.
- overrun  out  1  sticky: a result was lost.
- overrun_clr  in  1  clears overrun.

Function
REQ-006 SHALL implement FSM states IDLE, INIT, SAMP, COMP, UPDATE, DONE, plus a bit index k counting NBITS-1 down to 0.
REQ-007 In IDLE with start=1, SHALL enter INIT on that edge; start is ignored in every other state.
REQ-008 SHALL hold INIT for INIT_CYCLES, then SAMP for SAMP_CYCLES, then run COMP_CYCLES of COMP plus 1 cycle of UPDATE for each k.
REQ-009 After UPDATE with k=0, SHALL enter DONE for 1 cycle; from DONE, SHALL go to INIT if cont=1, else to IDLE.
REQ-010 Latency: result_valid SHALL rise exactly L=INIT_CYCLES+SAMP_CYCLES+NBITS*(COMP_CYCLES+1)+1 edges after the accepting edge (36 at defaults).
REQ-011 Strobes SHALL be Moore outputs:
- seq_init=INIT.
- seq_samp_p=SAMP&en_samp_p.
- seq_samp_n=SAMP&en_samp_n.
- seq_comp=COMP&en_comp.
- seq_update=UPDATE.
- At most one phase strobe family SHALL be high in any cycle.
REQ-012 On entering INIT, SHALL load dac_state_p<=dac_astate_p, dac_state_n<=dac_astate_n, and clear the internal shift code.
REQ-013 On the last COMP cycle, SHALL register decision d=comp_out_p.
REQ-014 In UPDATE for bit k:
- if d=1: dac_state_p[k]<=dac_bstate_p[k].
- if d=0: dac_state_n[k]<=dac_bstate_n[k].
- code[k]<=d.
- other bits unchanged.
REQ-015 On the DONE edge, SHALL copy code into result and set result_valid.
REQ-016 result_valid SHALL clear on any edge with result_valid&result_ready and no simultaneous DONE write.
REQ-017 DONE write with result_valid=1 and result_ready=0 SHALL overwrite result and set overrun.
REQ-018 DONE write with result_valid=1 and result_ready=1 SHALL load the new result, keep result_valid=1, and leave overrun unchanged.
REQ-019 overrun SHALL clear on overrun_clr; if a set and overrun_clr coincide, set SHALL win.
REQ-020 abort=1 SHALL force IDLE on the next edge from any state: no result write, dac_state holds, result register untouched.
REQ-021 The decision SHALL be taken only from comp_out_p; the n-side DAC acts on the complement of the same decision.

Reset
REQ-022 rst_b=0 SHALL immediately force:
- state IDLE, k=NBITS-1.
- all seq_* strobes, busy, result_valid and overrun 0.
- result, dac_state_p and dac_state_n all zero.
REQ-023 Reset mid-conversion SHALL discard the conversion; after release, no output changes until start is accepted.
REQ-024 Release of rst_b SHALL not itself start a conversion, even if start=1 during reset; start SHALL be sampled from the first edge after release.

Verification
REQ-025 Defaults, astate=0x0000, bstate=0xFFFF both sides, comp_out_p=1 always, single start -> result=0xFFFF, dac_state_p=0xFFFF, dac_state_n=0x0000, result_valid on edge 36.
REQ-026 Alternating decision 1,0,1,0... MSB first -> result=0xAAAA, dac_state_p=0xAAAA, dac_state_n=0x5555.
REQ-027 cont=1, result_ready=0 for two conversions -> second result overwrites, overrun=1; overrun_clr pulse -> overrun=0.
REQ-028 abort during COMP at k=7 -> IDLE next edge, result_valid stays 0, a new start converts correctly.
REQ-029 rst_b low during SAMP -> all outputs zero asynchronously; start=1 held across release -> INIT entered only after the first post-release edge.
REQ-030 NBITS=4, COMP_CYCLES=2, en_samp_n=0 -> seq_samp_n never high, result_valid at edge 1+2+12+1=16.
